// File: rtl/mem_responder.sv
// Byte-wide memory/IO responder: RAM with registered read, TX FIFO at 0x30000,
// RX holding register, and sticky halt/overflow flags.
module mem_responder #(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halted,
  output logic        tx_overflow
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [31:0] TX_ADDR   = 32'h0003_0000;
  localparam logic [31:0] CTRL_ADDR = 32'h0003_0004;
  localparam logic [PW:0] FULL_CNT  = (PW+1)'(TX_DEPTH);
  localparam logic [PW:0] HIGH_CNT  = (PW+1)'(TX_DEPTH - 1);

  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        fifo [TX_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              rx_full;
  logic [7:0]        rx_byte;
  logic [7:0]        ram_q;
  logic [7:0]        io_q;
  logic              ram_sel_q;
  logic [RAM_AW-1:0] ram_addr;

  logic       io_sel;
  logic       bus_rd;
  logic       bus_wr;
  logic       ram_we;
  logic       ram_re;
  logic       tx_push_req;
  logic       tx_push;
  logic       tx_pop;
  logic       halt_set;
  logic       rx_pop;
  logic       rx_capture;
  logic [7:0] io_rdata;

  assign ram_addr = mem_a[RAM_AW-1:0];

  always_comb begin
    io_sel      = (mem_a[17:16] == 2'b11);
    bus_rd      = rst_in && rdy_in && !mem_wr;
    bus_wr      = rst_in && rdy_in && mem_wr && !halted;
    ram_we      = bus_wr && !io_sel;
    ram_re      = bus_rd && !io_sel;
    tx_push_req = bus_wr && (mem_a == TX_ADDR);
    halt_set    = bus_wr && (mem_a == CTRL_ADDR);
    tx_pop      = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    tx_push     = tx_push_req && ((count != FULL_CNT) || tx_pop);
    rx_pop      = bus_rd && (mem_a == TX_ADDR) && rx_full;
    rx_capture  = rx_valid && rx_ready;
    io_rdata    = 8'h00;
    if (mem_a == TX_ADDR) begin
      if (rx_full) io_rdata = rx_byte;
    end else if (mem_a == CTRL_ADDR) begin
      io_rdata = {6'b0, tx_overflow, io_buffer_full};
    end
  end

  // Plain RAM port without reset so it maps onto block RAM; read-before-write.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= mem_dout;
    if (ram_re) ram_q <= ram[ram_addr];
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) fifo[wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      io_q        <= 8'h00;
      ram_sel_q   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_full     <= 1'b0;
      rx_byte     <= 8'h00;
      halted      <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (bus_rd) begin
        ram_sel_q <= !io_sel;
        if (io_sel) io_q <= io_rdata;
      end
      if (halt_set) halted <= 1'b1;
      if (tx_push_req && !tx_push) tx_overflow <= 1'b1;
      if (tx_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rx_capture) begin
        rx_full <= 1'b1;
        rx_byte <= rx_data;
      end else if (rx_pop) begin
        rx_full <= 1'b0;
      end
    end
  end

  // One spare slot remains when the flag rises, for a write already in flight.
  assign io_buffer_full = (count >= HIGH_CNT);
  assign tx_valid       = (count != '0);
  assign tx_data        = fifo[rd_ptr];
  assign rx_ready       = !rx_full;
  assign mem_din        = ram_sel_q ? ram_q : io_q;

endmodule
